mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single memory_controller port between the L1I refill path and the L1D read/write path.
- Serialises one transaction at a time through a registered-output FSM.
- Prioritises L1D, with an anti-starvation override for L1I and a bus timeout.
- Sits between the two l1 instances and memory_controller, and generates per-requester stall signals for the pipeline.

Parameters:
- ADDR_WIDTH, 32, address width of all ports.
- DATA_WIDTH, 32, data width of all ports.
- STARVE_LIMIT, 4, number of consecutive D grants while i_req is pending before I is forced to win.
- TIMEOUT_CYCLES, 255, cycles in a BUSY state without mc_ready before the transaction is aborted.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  L1I refill request; level, held until i_ready.
- i_address  in  ADDR_WIDTH  L1I refill address.
- i_ready  out  1  one-cycle pulse: i_data valid.
- i_data  out  DATA_WIDTH  refill data.
- i_stall  out  1  fetch must hold.
- d_req  in  1  L1D request; level, held until d_ready.
- d_write  in  1  1 = write, 0 = read.
- d_address  in  ADDR_WIDTH  L1D address.
- d_wdata  in  DATA_WIDTH  write data.
- d_ready  out  1  one-cycle pulse: transaction complete.
- d_data  out  DATA_WIDTH  read data.
- d_stall  out  1  mem stage must hold.
- mc_valid  out  1  transaction presented to memory_controller.
- mc_write  out  1  write strobe.
- mc_address  out  ADDR_WIDTH  transaction address.
- mc_wdata  out  DATA_WIDTH  write data.
- mc_ready  in  1  memory_controller completion.
- mc_rdata  in  DATA_WIDTH  read data from memory_controller.
- grant_owner  out  2  debug: 0 none, 1 I, 2 D.
- timeout_error  out  1  sticky; set on any timeout.

Behaviour:
- States: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; starve_cnt and timeout counter go to 0.
  - All outputs go to 0 immediately: mc_valid, mc_write, mc_address, mc_wdata, i_ready, d_ready, i_data, d_data, grant_owner, timeout_error.
  - An in-flight transaction is abandoned; no ready pulse is issued for it.
- IDLE arbitration, evaluated at each edge:
  - Only d_req high: go to BUSY_D.
  - Only i_req high: go to BUSY_I.
  - Both high: BUSY_D, unless starve_cnt == STARVE_LIMIT, in which case BUSY_I.
  - Neither high: stay in IDLE.
- Starvation counter:
  - starve_cnt increments (saturating at STARVE_LIMIT) on each D grant taken while i_req=1.
  - starve_cnt clears to 0 on any I grant.
- Grant:
  - On entering BUSY_x, latch address, wdata and write (write forced to 0 for I) into the mc_* registers.
  - Set mc_valid=1 and grant_owner to 1 (I) or 2 (D).
  - mc_* stay stable for the whole BUSY state, independent of later requester input changes.
- BUSY_x:
  - mc_ready=1 at an edge: capture mc_rdata (captured as 0 when mc_write=1), clear mc_valid, go to RESP_x.
  - Otherwise the timeout counter increments.
  - When the counter reaches TIMEOUT_CYCLES: clear mc_valid, set timeout_error, capture data as 0, go to RESP_x.
  - The timeout counter clears on entering BUSY.
- RESP_x:
  - Lasts exactly one cycle: x_ready=1, x_data holds the captured value, grant_owner=0.
  - Next state is always IDLE.
  - This bubble guarantees the requester has dropped req before re-arbitration, so there are no duplicate grants.
  - x_data holds its value until the next response to the same requester.
- Minimum latency:
  - req high in cycle 0 → mc_valid in cycle 1.
  - mc_ready in cycle 1 → ready pulse in cycle 2.
  - Earliest next grant is in cycle 4, i.e. one IDLE cycle after RESP.
- Stalls (combinational from state and req):
  - i_stall = i_req & ~(state==RESP_I).
  - d_stall = d_req & ~(state==RESP_D).
  - A requester not being served stalls the whole time its req is high.
- Edge cases:
  - mc_ready while in IDLE or RESP is ignored.
  - A req dropped during BUSY does not abort; RESP still pulses and the pulse is ignorable.
  - timeout_error is cleared only by reset.

Test Plan:
- Single D read at 0x0000_0100, mc_ready 3 cycles after mc_valid with mc_rdata=0xCAFEF00D → mc_valid high for 3 cycles, mc_write=0; then d_ready pulses 1 cycle with d_data=0xCAFEF00D; i_ready stays 0.
- Simultaneous i_req (0x40) and d_req write (0x200, wdata 0x12345678), mc_ready=1 immediately → D served first (mc_write=1, mc_wdata=0x12345678, grant_owner=2), then I at 0x40 (grant_owner=1); i_stall high throughout D service.
- i_req held high while d_req is reasserted immediately after each response, 6 times → grants D,D,D,D,I,D (STARVE_LIMIT=4).
- Change d_address from 0x100 to 0x999 mid-BUSY → mc_address stays 0x100 until RESP.
- mc_ready never asserted → after 255 BUSY cycles mc_valid drops, d_ready pulses with d_data=0, timeout_error=1 and stays 1 through later successful transactions.
- Assert reset=0 asynchronously mid-BUSY_I → mc_valid, grant_owner and i_ready drop to 0 before the next clock edge; after release with i_req still high, I is re-granted from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory_controller port between the L1I refill path and
// the L1D read/write path, one transaction at a time, with D priority.
module mem_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic                  i_ready,
    output logic [DATA_WIDTH-1:0] i_data,
    output logic                  i_stall,
    input  logic                  d_req,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ready,
    output logic [DATA_WIDTH-1:0] d_data,
    output logic                  d_stall,
    output logic                  mc_valid,
    output logic                  mc_write,
    output logic [ADDR_WIDTH-1:0] mc_address,
    output logic [DATA_WIDTH-1:0] mc_wdata,
    input  logic                  mc_ready,
    input  logic [DATA_WIDTH-1:0] mc_rdata,
    output logic [1:0]            grant_owner,
    output logic                  timeout_error
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STARVE_MAX   = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        RESP_I = 3'd3,
        RESP_D = 3'd4
    } state_t;

    state_t          state_reg;
    logic [SW-1:0]   starve_cnt_reg;
    logic [TW-1:0]   timeout_cnt_reg;

    logic            i_forced;
    logic            busy_done;
    logic            busy_timeout;
    logic [DATA_WIDTH-1:0] resp_data;

    // I wins a contested arbitration only once D has starved it STARVE_LIMIT times.
    assign i_forced     = i_req && (starve_cnt_reg == STARVE_MAX);
    assign busy_timeout = !mc_ready && (timeout_cnt_reg == TIMEOUT_LAST);
    assign busy_done    = mc_ready || busy_timeout;
    assign resp_data    = (mc_ready && !mc_write) ? mc_rdata : '0;

    assign i_stall = i_req && (state_reg != RESP_I);
    assign d_stall = d_req && (state_reg != RESP_D);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg       <= IDLE;
            starve_cnt_reg  <= '0;
            timeout_cnt_reg <= '0;
            mc_valid        <= 1'b0;
            mc_write        <= 1'b0;
            mc_address      <= '0;
            mc_wdata        <= '0;
            i_ready         <= 1'b0;
            d_ready         <= 1'b0;
            i_data          <= '0;
            d_data          <= '0;
            grant_owner     <= 2'd0;
            timeout_error   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    timeout_cnt_reg <= '0;
                    if (d_req && !i_forced) begin
                        state_reg   <= BUSY_D;
                        mc_valid    <= 1'b1;
                        mc_write    <= d_write;
                        mc_address  <= d_address;
                        mc_wdata    <= d_wdata;
                        grant_owner <= 2'd2;
                        if (i_req && starve_cnt_reg != STARVE_MAX)
                            starve_cnt_reg <= starve_cnt_reg + 1'b1;
                    end else if (i_req) begin
                        state_reg      <= BUSY_I;
                        mc_valid       <= 1'b1;
                        mc_write       <= 1'b0;
                        mc_address     <= i_address;
                        mc_wdata       <= '0;
                        grant_owner    <= 2'd1;
                        starve_cnt_reg <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (busy_done) begin
                        mc_valid    <= 1'b0;
                        grant_owner <= 2'd0;
                        if (busy_timeout)
                            timeout_error <= 1'b1;
                        if (state_reg == BUSY_I) begin
                            state_reg <= RESP_I;
                            i_ready   <= 1'b1;
                            i_data    <= resp_data;
                        end else begin
                            state_reg <= RESP_D;
                            d_ready   <= 1'b1;
                            d_data    <= resp_data;
                        end
                    end else begin
                        timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
                    end
                end
                RESP_I, RESP_D: begin
                    i_ready   <= 1'b0;
                    d_ready   <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg   <= IDLE;
                    mc_valid    <= 1'b0;
                    grant_owner <= 2'd0;
                    i_ready     <= 1'b0;
                    d_ready     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: drives and samples on the falling edge,
// with expected values worked out by hand for each scenario.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_address = '0;
    logic        i_ready;
    logic [31:0] i_data;
    logic        i_stall;
    logic        d_req = 1'b0;
    logic        d_write = 1'b0;
    logic [31:0] d_address = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ready;
    logic [31:0] d_data;
    logic        d_stall;
    logic        mc_valid;
    logic        mc_write;
    logic [31:0] mc_address;
    logic [31:0] mc_wdata;
    logic        mc_ready = 1'b0;
    logic [31:0] mc_rdata = '0;
    logic [1:0]  grant_owner;
    logic        timeout_error;

    int checks   = 0;
    int failures = 0;
    int grants [6];
    int exp_grants [6] = '{2, 2, 2, 2, 1, 2};
    int ng;
    int nvalid;

    mem_port_arbiter dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_address(i_address), .i_ready(i_ready), .i_data(i_data), .i_stall(i_stall),
        .d_req(d_req), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_data(d_data), .d_stall(d_stall),
        .mc_valid(mc_valid), .mc_write(mc_write), .mc_address(mc_address), .mc_wdata(mc_wdata),
        .mc_ready(mc_ready), .mc_rdata(mc_rdata),
        .grant_owner(grant_owner), .timeout_error(timeout_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One line per completed transaction.
    always @(negedge clock) begin
        if (i_ready) $display("txn I data=0x%08h timeout_error=%0d", i_data, timeout_error);
        if (d_ready) $display("txn D data=0x%08h timeout_error=%0d", d_data, timeout_error);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        @(negedge clock);
        @(negedge clock);
        check("rst_mc_valid", mc_valid, 0);
        check("rst_owner", grant_owner, 0);
        check("rst_timeout", timeout_error, 0);
        check("rst_ready", {i_ready, d_ready}, 0);
        check("rst_addr", mc_address, 0);
        reset = 1'b1;
        @(negedge clock);

        // Single D read, mc_ready three cycles into BUSY
        d_req = 1; d_write = 0; d_address = 32'h0000_0100;
        @(negedge clock);
        check("rd_valid_c1", mc_valid, 1);
        check("rd_write", mc_write, 0);
        check("rd_addr", mc_address, 32'h100);
        check("rd_owner", grant_owner, 2);
        check("rd_dstall", d_stall, 1);
        @(negedge clock);
        check("rd_valid_c2", mc_valid, 1);
        @(negedge clock);
        check("rd_valid_c3", mc_valid, 1);
        mc_ready = 1; mc_rdata = 32'hCAFE_F00D;
        @(negedge clock);
        mc_ready = 0;
        check("rd_valid_drop", mc_valid, 0);
        check("rd_dready", d_ready, 1);
        check("rd_ddata", d_data, 32'hCAFE_F00D);
        check("rd_dstall_resp", d_stall, 0);
        check("rd_iready", i_ready, 0);
        check("rd_owner_resp", grant_owner, 0);
        d_req = 0;
        @(negedge clock);
        check("rd_dready_pulse", d_ready, 0);
        check("rd_ddata_hold", d_data, 32'hCAFE_F00D);

        // Simultaneous requests, memory answers immediately
        i_req = 1; i_address = 32'h40;
        d_req = 1; d_write = 1; d_address = 32'h200; d_wdata = 32'h1234_5678;
        mc_ready = 1; mc_rdata = 32'h0BAD_BEEF;
        @(negedge clock);
        check("both_owner_d", grant_owner, 2);
        check("both_wr", mc_write, 1);
        check("both_wdata", mc_wdata, 32'h1234_5678);
        check("both_addr_d", mc_address, 32'h200);
        check("both_istall_busy", i_stall, 1);
        @(negedge clock);
        check("both_dready", d_ready, 1);
        check("both_ddata_wr0", d_data, 0);
        check("both_istall_resp", i_stall, 1);
        d_req = 0; d_write = 0;
        @(negedge clock);
        check("both_idle_owner", grant_owner, 0);
        check("both_istall_idle", i_stall, 1);
        @(negedge clock);
        check("both_owner_i", grant_owner, 1);
        check("both_addr_i", mc_address, 32'h40);
        check("both_wr_i", mc_write, 0);
        @(negedge clock);
        check("both_iready", i_ready, 1);
        check("both_idata", i_data, 32'h0BAD_BEEF);
        check("both_istall_done", i_stall, 0);
        i_req = 0;
        @(negedge clock);
        check("both_iready_pulse", i_ready, 0);

        // Starvation override: i_req held while D keeps requesting
        i_req = 1; i_address = 32'h80; d_req = 1; d_address = 32'h300;
        ng = 0;
        for (int c = 0; c < 40 && ng < 6; c++) begin
            @(negedge clock);
            if (i_ready) i_req = 0;
            if (grant_owner != 0) begin
                grants[ng] = int'(grant_owner);
                ng++;
            end
        end
        d_req = 0;
        check("starve_ngrants", ng, 6);
        for (int k = 0; k < 6; k++)
            check($sformatf("starve_grant%0d", k), grants[k], exp_grants[k]);
        @(negedge clock);
        @(negedge clock);
        mc_ready = 0; i_req = 0;

        // Address stability while the requester changes its inputs
        d_req = 1; d_write = 0; d_address = 32'h100;
        @(negedge clock);
        check("stab_addr_c1", mc_address, 32'h100);
        d_address = 32'h999; d_wdata = 32'h5555_AAAA; d_write = 1;
        @(negedge clock);
        check("stab_addr_c2", mc_address, 32'h100);
        check("stab_write_c2", mc_write, 0);
        @(negedge clock);
        check("stab_addr_c3", mc_address, 32'h100);
        mc_ready = 1; mc_rdata = 32'h1111_2222;
        @(negedge clock);
        mc_ready = 0;
        check("stab_dready", d_ready, 1);
        check("stab_ddata", d_data, 32'h1111_2222);
        d_req = 0; d_write = 0;
        @(negedge clock);

        // Bus timeout: mc_ready never comes
        d_req = 1; d_write = 0; d_address = 32'h400;
        nvalid = 0;
        @(negedge clock);
        while (mc_valid && nvalid < 300) begin
            nvalid++;
            @(negedge clock);
        end
        check("to_valid_cycles", nvalid, 255);
        check("to_dready", d_ready, 1);
        check("to_ddata", d_data, 0);
        check("to_error", timeout_error, 1);
        d_req = 0;
        @(negedge clock);
        d_req = 1; d_address = 32'h500; mc_ready = 1; mc_rdata = 32'h7777_0001;
        @(negedge clock);
        @(negedge clock);
        check("to_next_dready", d_ready, 1);
        check("to_next_ddata", d_data, 32'h7777_0001);
        check("to_sticky", timeout_error, 1);
        d_req = 0; mc_ready = 0;
        @(negedge clock);

        // Asynchronous reset in the middle of an I transaction
        i_req = 1; i_address = 32'h80;
        @(negedge clock);
        check("ar_owner_busy", grant_owner, 1);
        check("ar_valid_busy", mc_valid, 1);
        #2 reset = 1'b0;
        #1;
        check("ar_valid", mc_valid, 0);
        check("ar_owner", grant_owner, 0);
        check("ar_iready", i_ready, 0);
        check("ar_error_cleared", timeout_error, 0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("ar_regrant_owner", grant_owner, 1);
        check("ar_regrant_addr", mc_address, 32'h80);
        mc_ready = 1; mc_rdata = 32'hABCD_0123;
        @(negedge clock);
        check("ar_iready_done", i_ready, 1);
        check("ar_idata", i_data, 32'hABCD_0123);
        i_req = 0; mc_ready = 0;
        @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
